// File: rtl/noc_local_arbiter.sv
// Burst-limited round-robin arbiter that shares one router local injection
// port among NUM_REQ requesters through a single output flit register.
module noc_local_arbiter #(
  parameter int DATA_WIDTH = 216,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_busy,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          active
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_burst_cnt, w_burst_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  logic                  w_can_load;
  logic                  w_xfer;
  logic                  w_any_req;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_release_ptr;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_sel_data;

  assign w_any_req     = |req_valid;
  assign w_can_load    = !r_out_valid || !out_busy;
  assign w_xfer        = (r_state == GRANT) && req_valid[r_grant_idx] && w_can_load;
  assign w_cnt_inc     = r_burst_cnt + 1'b1;
  assign w_release_ptr = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;
  assign w_sel_data    = req_data[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    int               v_pos;
    logic [IDX_W-1:0] v_idx;
    w_sel_idx = r_rr_ptr;
    v_pos     = 0;
    v_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_pos = (int'(r_rr_ptr) + k) % NUM_REQ;
      v_idx = IDX_W'(v_pos);
      if (req_valid[v_idx]) w_sel_idx = v_idx;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = GRANT;
          w_grant_idx_nxt = w_sel_idx;
          w_burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        // A flit that transfers on the same edge valid drops is a transfer, not a release.
        if (w_xfer) begin
          w_burst_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == BURST_MAX) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = w_release_ptr;
          end
        end else if (!req_valid[r_grant_idx]) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = w_release_ptr;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Output flit register: load on a requester transfer, otherwise drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
    end else if (r_out_valid && !out_busy) begin
      r_out_valid <= 1'b0;
    end
  end

  assign active    = (r_state == GRANT);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_comb begin
    grant = '0;
    if (active) grant[r_grant_idx] = 1'b1;
  end

  always_comb begin
    req_busy = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active && (r_grant_idx == IDX_W'(i)) && w_can_load) req_busy[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_local_arbiter.sv
// Randomised and directed bench for noc_local_arbiter: behavioural sources,
// a turn-based arbitration model and a per-requester in-order scoreboard.
module tb_noc_local_arbiter;
  localparam int DW       = 32;
  localparam int N        = 4;
  localparam int B        = 4;
  localparam int WAIT_MAX = (N - 1) * (B + 1) + 1;  // includes the lost arbitration cycle

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_busy;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_busy;
  logic [N-1:0]    grant;
  logic            active;

  noc_local_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(B)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_busy(req_busy), .out_data(out_data), .out_valid(out_valid),
    .out_busy(out_busy), .grant(grant), .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] src_v;
  int           src_seq[N];
  int           src_left[N];
  int           src_pct;
  logic         obusy;
  int           exp_seq[N];
  int           wait_cnt[N];
  int           max_wait[N];

  logic          m_on;
  int            m_idx;
  int            m_rr;
  int            m_cnt;
  logic          m_ov;
  logic [DW-1:0] m_od;

  logic [N-1:0]  s_grant, s_busy;
  logic          s_ov;
  logic [DW-1:0] s_od;
  logic [DW-1:0] outq[$];
  logic [N-1:0]  glog[64];
  int            cyc;

  function automatic logic [DW-1:0] flit(input int i, input int s);
    logic [7:0]  id;
    logic [23:0] sq;
    id = i[7:0];
    sq = s[23:0];
    return {id, sq};
  endfunction

  task automatic reset_model();
    m_on = 1'b0; m_idx = 0; m_rr = 0; m_cnt = 0; m_ov = 1'b0; m_od = '0;
    for (int i = 0; i < N; i++) begin
      exp_seq[i]  = src_seq[i];
      wait_cnt[i] = 0;
      max_wait[i] = 0;
    end
    cyc = 0;
    outq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_v = '0; req_valid = '0; obusy = 1'b0; out_busy = 1'b0; src_pct = 100;
    for (int i = 0; i < N; i++) begin
      src_left[i] = 0;
      req_data[i*DW +: DW] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  // One clock cycle: drive, sample, compare against the model, advance sources.
  task automatic step();
    logic [N-1:0] fired, exp_busy, exp_grant;
    logic         can, xfer, found;
    logic [7:0]   o_id;
    logic [23:0]  o_seq;
    int           cand;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = flit(i, src_seq[i]);
    req_valid = src_v;
    out_busy  = obusy;
    #1;
    s_grant = grant; s_busy = req_busy; s_ov = out_valid; s_od = out_data;
    if (cyc < 64) glog[cyc] = grant;

    exp_grant = m_on ? (N'(1) << m_idx) : '0;
    can = !m_ov || !obusy;
    for (int i = 0; i < N; i++) exp_busy[i] = !(m_on && (m_idx == i) && can);

    n_checks++;
    if (grant !== exp_grant) begin
      n_errors++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant);
    end
    n_checks++;
    if (active !== m_on) begin
      n_errors++; $display("FAIL active cyc=%0d got=%b exp=%b", cyc, active, m_on);
    end
    n_checks++;
    if (req_busy !== exp_busy) begin
      n_errors++; $display("FAIL req_busy cyc=%0d got=%b exp=%b", cyc, req_busy, exp_busy);
    end
    n_checks++;
    if (out_valid !== m_ov) begin
      n_errors++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ov);
    end
    n_checks++;
    if (out_data !== m_od) begin
      n_errors++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, m_od);
    end

    if (out_valid && !out_busy) begin
      o_id = out_data[31:24]; o_seq = out_data[23:0];
      n_checks++;
      if (o_id >= 8'(N)) begin
        n_errors++; $display("FAIL out_id cyc=%0d got=%0d exp=<%0d", cyc, o_id, N);
      end else begin
        if (int'(o_seq) != exp_seq[o_id]) begin
          n_errors++;
          $display("FAIL order req%0d cyc=%0d got_seq=%0d exp_seq=%0d", o_id, cyc, o_seq, exp_seq[o_id]);
        end
        exp_seq[o_id] = int'(o_seq) + 1;
      end
      outq.push_back(out_data);
    end

    fired = req_valid & ~req_busy;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) wait_cnt[i] = 0;
      else if (src_v[i] && !obusy) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
      end
    end

    // Turn-based model: a turn ends after B flits or when its owner goes quiet.
    xfer = m_on && src_v[m_idx] && can;
    if (xfer) begin
      m_od = flit(m_idx, src_seq[m_idx]); m_ov = 1'b1;
    end else if (m_ov && !obusy) m_ov = 1'b0;
    if (!m_on) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        cand = (m_rr + k) % N;
        if (!found && src_v[cand]) begin
          found = 1'b1; m_idx = cand;
        end
      end
      if (found) begin
        m_on = 1'b1; m_cnt = 0;
      end
    end else if (xfer) begin
      m_cnt++;
      if (m_cnt == B) begin
        m_on = 1'b0; m_rr = (m_idx + 1) % N;
      end
    end else if (!src_v[m_idx]) begin
      m_on = 1'b0; m_rr = (m_idx + 1) % N;
    end

    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        src_seq[i]++;
        if (src_left[i] > 0) src_left[i]--;
        src_v[i] = (src_left[i] > 0) && ($urandom_range(99) < src_pct);
      end else if (!src_v[i] && src_left[i] > 0 && $urandom_range(99) < src_pct) begin
        src_v[i] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic clear_seq();
    for (int i = 0; i < N; i++) src_seq[i] = 0;
  endtask

  task automatic test_reset();
    clear_seq();
    rst = 1'b1; src_v = '0; req_valid = '0; out_busy = 1'b0; obusy = 1'b0; req_data = '0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++; $display("FAIL rst_out got=%b/%h exp=0/0", out_valid, out_data);
    end
    n_checks++;
    if (req_busy !== 4'b1111 || grant !== 4'b0000 || active !== 1'b0) begin
      n_errors++; $display("FAIL rst_ctrl got busy=%b grant=%b active=%b exp=1111/0000/0", req_busy, grant, active);
    end
    do_reset();
    src_left[0] = 100; src_v[0] = 1'b1;
    repeat (3) step();
    n_checks++;
    if (s_ov !== 1'b1) begin
      n_errors++; $display("FAIL pre_rst_valid got=%b exp=1", s_ov);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0000 || req_busy !== 4'b1111) begin
      n_errors++; $display("FAIL async_rst got valid=%b grant=%b busy=%b exp=0/0000/1111", out_valid, grant, req_busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (s_ov !== (c == 2)) begin
        n_errors++; $display("FAIL post_rst_valid c=%0d got=%b exp=%b", c, s_ov, (c == 2));
      end
    end
    n_checks++;
    if (s_od !== flit(0, 2)) begin
      n_errors++; $display("FAIL post_rst_data got=%h exp=%h", s_od, flit(0, 2));
    end
  endtask

  task automatic test_single();
    clear_seq();
    do_reset();
    src_left[2] = 10; src_v[2] = 1'b1;
    repeat (16) step();
    n_checks++;
    if (glog[1] !== 4'b0100 || glog[6] !== 4'b0100 || glog[11] !== 4'b0100) begin
      n_errors++; $display("FAIL single_grant got=%b,%b,%b exp=0100", glog[1], glog[6], glog[11]);
    end
    n_checks++;
    if (glog[5] !== 4'b0000 || glog[10] !== 4'b0000) begin
      n_errors++; $display("FAIL single_bubble got=%b,%b exp=0000", glog[5], glog[10]);
    end
    n_checks++;
    if (outq.size() != 10) begin
      n_errors++; $display("FAIL single_count got=%0d exp=10", outq.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        n_checks++;
        if (outq[k] !== flit(2, k)) begin
          n_errors++; $display("FAIL single_flit%0d got=%h exp=%h", k, outq[k], flit(2, k));
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] exp_g[5];
    clear_seq();
    do_reset();
    for (int i = 0; i < N; i++) begin
      src_left[i] = 1000; src_v[i] = 1'b1;
    end
    repeat (26) step();
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      n_checks++;
      if (glog[1 + 5*t] !== exp_g[t] || (t > 0 && glog[5*t] !== 4'b0000)) begin
        n_errors++; $display("FAIL rr_turn%0d got=%b (prev %b) exp=%b", t, glog[1 + 5*t], glog[5*t], exp_g[t]);
      end
    end
    n_checks++;
    if (outq.size() != 20) begin
      n_errors++; $display("FAIL rr_count got=%0d exp=20", outq.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        n_checks++;
        if (outq[k] !== flit((k / 4) % N, (k / 16) * 4 + (k % 4))) begin
          n_errors++; $display("FAIL rr_flit%0d got=%h exp=%h", k, outq[k], flit((k / 4) % N, (k / 16) * 4 + (k % 4)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_seq();
    do_reset();
    src_left[0] = 10; src_v[0] = 1'b1;
    for (int c = 0; c < 26; c++) begin
      obusy = (c >= 3 && c <= 7);
      step();
      if (c >= 3 && c <= 7) begin
        n_checks++;
        if (s_busy[0] !== 1'b1 || s_ov !== 1'b1 || s_od !== flit(0, 1)) begin
          n_errors++; $display("FAIL hold c=%0d got busy=%b valid=%b data=%h exp=1/1/%h", c, s_busy[0], s_ov, s_od, flit(0, 1));
        end
      end
    end
    n_checks++;
    if (outq.size() != 10) begin
      n_errors++; $display("FAIL bp_count got=%0d exp=10", outq.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        n_checks++;
        if (outq[k] !== flit(0, k)) begin
          n_errors++; $display("FAIL bp_flit%0d got=%h exp=%h", k, outq[k], flit(0, k));
        end
      end
    end
  endtask

  task automatic test_early_release();
    int n1;
    clear_seq();
    do_reset();
    src_left[1] = 2; src_v[1] = 1'b1;
    src_left[3] = 4; src_v[3] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin
        src_left[0] = 4; src_v[0] = 1'b1;
      end
      step();
    end
    n_checks++;
    if (glog[1] !== 4'b0010 || glog[3] !== 4'b0010 || glog[4] !== 4'b0000) begin
      n_errors++; $display("FAIL release got=%b,%b,%b exp=0010,0010,0000", glog[1], glog[3], glog[4]);
    end
    n_checks++;
    if (glog[5] !== 4'b1000) begin
      n_errors++; $display("FAIL release_next got=%b exp=1000", glog[5]);
    end
    n_checks++;
    if (glog[9] !== 4'b0000 || glog[10] !== 4'b0001) begin
      n_errors++; $display("FAIL release_wrap got=%b,%b exp=0000,0001", glog[9], glog[10]);
    end
    n1 = 0;
    foreach (outq[k]) if (outq[k][31:24] == 8'd1) n1++;
    n_checks++;
    if (n1 != 2) begin
      n_errors++; $display("FAIL release_flits got=%0d exp=2", n1);
    end
  endtask

  task automatic test_random();
    int total;
    do_reset();
    src_pct = 60;
    for (int i = 0; i < N; i++) src_left[i] = 1 << 30;
    for (int c = 0; c < 10000; c++) begin
      obusy = ($urandom_range(99) < 30);
      step();
    end
    obusy = 1'b0;
    for (int i = 0; i < N; i++) src_left[i] = 0;
    repeat (40) step();
    total = 0;
    for (int i = 0; i < N; i++) begin
      total += src_seq[i];
      n_checks++;
      if (exp_seq[i] != src_seq[i] || src_v[i]) begin
        n_errors++; $display("FAIL rand_drain req%0d got_out=%0d exp_sent=%0d", i, exp_seq[i], src_seq[i]);
      end
      n_checks++;
      if (max_wait[i] > WAIT_MAX) begin
        n_errors++; $display("FAIL rand_wait req%0d got=%0d exp<=%0d", i, max_wait[i], WAIT_MAX);
      end
    end
    n_checks++;
    if (total < 2000) begin
      n_errors++; $display("FAIL rand_traffic got=%0d exp>=2000", total);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_early_release();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
